// File: rtl/mem_access_scheduler.sv
// rtl/mem_access_scheduler.sv - per-sample memory sequencer for the convolution-reverb path
// Writes each new sample into the ring, then streams coefficient/delayed-sample pairs to the MAC.
module mem_access_scheduler #(
   parameter logic [15:0] IMPULSE_LENGTH = 16'h00FF,
   parameter logic [15:0] RING_END       = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_tick,
   input  logic        record_en,
   input  logic [15:0] sample_in,
   input  logic [15:0] tap_count,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] coef_out,
   output logic [15:0] samp_out,
   output logic        pair_valid,
   output logic        frame_done,
   output logic        busy,
   output logic        overrun
);
   localparam logic [16:0] RING_SIZE = {1'b0, RING_END} - {1'b0, IMPULSE_LENGTH} + 17'd1;
   localparam logic [16:0] TAP_LIMIT = ({1'b0, IMPULSE_LENGTH} < RING_SIZE) ? {1'b0, IMPULSE_LENGTH} : RING_SIZE;

   typedef enum logic [2:0] {IDLE, WRITE, RD_COEF, RD_SAMP, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] wp_q, wp_d, k_q, k_d, taps_q, taps_d;
   logic [15:0] samp_lat_q, samp_lat_d, coef_hold_q, coef_hold_d;
   logic [15:0] coef_out_q, coef_out_d, samp_out_q, samp_out_d;
   logic        wrote_q, wrote_d, overrun_q, overrun_d, pair_valid_q, pair_valid_d;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, frame_done_q, frame_done_d, busy_q, busy_d;
   logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [16:0] ring_diff, ring_addr;

   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      k_d          = k_q;
      taps_d       = taps_q;
      samp_lat_d   = samp_lat_q;
      coef_hold_d  = coef_hold_q;
      coef_out_d   = coef_out_q;
      samp_out_d   = samp_out_q;
      wrote_d      = wrote_q;
      overrun_d    = overrun_q;
      pair_valid_d = 1'b0;
      case (state_q)
         IDLE: if (sample_tick) begin
            samp_lat_d = sample_in;
            taps_d     = ({1'b0, tap_count} < TAP_LIMIT) ? tap_count : TAP_LIMIT[15:0];
            k_d        = 16'd0;
            wrote_d    = record_en;
            if (record_en)        state_d = WRITE;
            else if (taps_d != 0) state_d = RD_COEF;
            else                  state_d = DONE;
         end
         WRITE: if (mem_ready) state_d = (taps_q != 0) ? RD_COEF : DONE;
         RD_COEF: if (mem_ready) begin
            coef_hold_d = mem_rdata;
            state_d     = RD_SAMP;
         end
         RD_SAMP: if (mem_ready) begin
            coef_out_d   = coef_hold_q;
            samp_out_d   = mem_rdata;
            pair_valid_d = 1'b1;
            k_d          = k_q + 16'd1;
            state_d      = (k_q + 16'd1 == taps_q) ? DONE : RD_COEF;
         end
         DONE: begin
            state_d = IDLE;
            if (wrote_q) wp_d = (wp_q == RING_END) ? IMPULSE_LENGTH : wp_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
      // A tick that lands mid-frame is dropped; only the sticky flag records it.
      if (sample_tick && state_q != IDLE) overrun_d = 1'b1;

      // Outputs are decoded from the next state so they line up with the state register.
      ring_diff    = {1'b0, wp_d} - {1'b0, k_d};
      ring_addr    = (ring_diff < {1'b0, IMPULSE_LENGTH}) ? ring_diff + RING_SIZE : ring_diff;
      mem_req_d    = (state_d == WRITE) || (state_d == RD_COEF) || (state_d == RD_SAMP);
      mem_we_d     = (state_d == WRITE);
      mem_wdata_d  = (state_d == WRITE) ? samp_lat_d : 16'd0;
      frame_done_d = (state_d == DONE);
      busy_d       = (state_d != IDLE);
      case (state_d)
         WRITE:   mem_addr_d = wp_d;
         RD_COEF: mem_addr_d = k_d;
         RD_SAMP: mem_addr_d = ring_addr[15:0];
         default: mem_addr_d = 16'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wp_q         <= IMPULSE_LENGTH;
         k_q          <= 16'd0;
         taps_q       <= 16'd0;
         samp_lat_q   <= 16'd0;
         coef_hold_q  <= 16'd0;
         coef_out_q   <= 16'd0;
         samp_out_q   <= 16'd0;
         wrote_q      <= 1'b0;
         overrun_q    <= 1'b0;
         pair_valid_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 16'd0;
         mem_wdata_q  <= 16'd0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         k_q          <= k_d;
         taps_q       <= taps_d;
         samp_lat_q   <= samp_lat_d;
         coef_hold_q  <= coef_hold_d;
         coef_out_q   <= coef_out_d;
         samp_out_q   <= samp_out_d;
         wrote_q      <= wrote_d;
         overrun_q    <= overrun_d;
         pair_valid_q <= pair_valid_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign coef_out   = coef_out_q;
   assign samp_out   = samp_out_q;
   assign pair_valid = pair_valid_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb/tb_mem_access_scheduler.sv - randomized bench for mem_access_scheduler
// Bench-owned memory plus a frame-level model of the expected access and pair streams.
module tb_mem_access_scheduler;
   localparam int IL = 4;
   localparam int R  = 6;

   logic clk = 1'b0;
   logic rst, sample_tick, record_en, mem_ready;
   logic [15:0] sample_in, tap_count, mem_rdata;
   logic mem_req, mem_we, pair_valid, frame_done, busy, overrun;
   logic [15:0] mem_addr, mem_wdata, coef_out, samp_out;

   always #5 clk = ~clk;

   mem_access_scheduler #(.IMPULSE_LENGTH(16'd4), .RING_END(16'd9)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .record_en(record_en),
      .sample_in(sample_in), .tap_count(tap_count), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .coef_out(coef_out), .samp_out(samp_out), .pair_valid(pair_valid),
      .frame_done(frame_done), .busy(busy), .overrun(overrun)
   );

   logic [15:0] mem [0:15];
   logic [15:0] shadow [0:15];
   assign mem_rdata = mem[mem_addr[3:0]];
   always @(posedge clk) if (mem_req && mem_ready && mem_we) mem[mem_addr[3:0]] <= mem_wdata;

   typedef struct {logic we; logic [15:0] addr; logic [15:0] data;} acc_t;
   acc_t exp_acc[$];
   logic [31:0] exp_pair[$];
   logic [15:0] log_addr[$];
   logic log_we[$];

   int checks = 0, errors = 0, cyc = 0;
   int mode = 0, rcnt = 0;
   int wp_m, exp_taps, exp_lat, frame_rec;
   int tick_cyc, done_cyc, first_pair_cyc, pairs_seen, req_cycles;
   logic stall_prev = 1'b0, p_we;
   logic [15:0] p_addr, p_wdata;
   logic [31:0] last_pair = 32'd0;
   logic [15:0] lit_addr [7] = '{16'd4, 16'd0, 16'd4, 16'd1, 16'd9, 16'd2, 16'd8};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (mode)
         0: mem_ready = 1'b1;
         1: if (!mem_req) begin mem_ready = 1'b0; rcnt = 0; end
            else if (rcnt < 3) begin mem_ready = 1'b0; rcnt++; end
            else begin mem_ready = 1'b1; rcnt = 0; end
         default: mem_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         last_pair  = 32'd0;
      end else begin
         if (mem_req) req_cycles++;
         if (stall_prev) begin
            chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, p_addr);
            chk("hold_we", mem_we, p_we);
            chk("hold_wdata", mem_wdata, p_wdata);
         end
         stall_prev = mem_req && !mem_ready;
         p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
         if (mem_req && mem_ready) begin
            acc_t e;
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            chk("access_expected", exp_acc.size() > 0, 1);
            if (exp_acc.size() > 0) begin
               e = exp_acc.pop_front();
               chk("acc_we", mem_we, e.we);
               chk("acc_addr", mem_addr, e.addr);
               if (e.we) chk("acc_wdata", mem_wdata, e.data);
            end
         end
         if (pair_valid) begin
            pairs_seen++;
            if (first_pair_cyc < 0) first_pair_cyc = cyc;
            chk("pair_expected", exp_pair.size() > 0, 1);
            if (exp_pair.size() > 0) chk("pair_value", {coef_out, samp_out}, exp_pair.pop_front());
            last_pair = {coef_out, samp_out};
         end else begin
            chk("pair_hold", {coef_out, samp_out}, last_pair);
         end
      end
   end

   task automatic start_frame(input int rec, input int tc, input logic [15:0] smp);
      int ra;
      exp_taps = tc;
      if (exp_taps > IL) exp_taps = IL;
      if (exp_taps > R) exp_taps = R;
      frame_rec = rec;
      exp_lat = rec + 2 * exp_taps + 1;
      if (rec != 0) begin
         shadow[wp_m] = smp;
         exp_acc.push_back('{1'b1, 16'(wp_m), smp});
      end
      for (int k = 0; k < exp_taps; k++) begin
         ra = IL + ((wp_m - IL - k + R) % R);
         exp_acc.push_back('{1'b0, 16'(k), 16'd0});
         exp_acc.push_back('{1'b0, 16'(ra), 16'd0});
         exp_pair.push_back({shadow[k], shadow[ra]});
      end
      @(posedge clk); #1;
      record_en = rec[0]; tap_count = 16'(tc); sample_in = smp; sample_tick = 1'b1;
      tick_cyc = cyc; pairs_seen = 0; req_cycles = 0; first_pair_cyc = -1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
   endtask

   task automatic wait_frame();
      int seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (frame_done) begin seen = 1; break; end
      end
      #1;
      done_cyc = cyc;
      chk("frame_done_seen", seen, 1);
      if (mode == 0) chk("frame_latency", done_cyc - tick_cyc, exp_lat);
      chk("pair_count", pairs_seen, exp_taps);
      chk("accesses_left", exp_acc.size(), 0);
      if (frame_rec != 0) wp_m = IL + ((wp_m - IL + 1) % R);
   endtask

   task automatic frame(input int rec, input int tc, input logic [15:0] smp);
      start_frame(rec, tc, smp);
      wait_frame();
   endtask

   task automatic do_reset(input logic with_tick);
      @(posedge clk); #1;
      rst = 1'b1; sample_tick = with_tick; record_en = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_acc.delete(); exp_pair.delete();
      wp_m = IL;
      for (int i = 0; i < 16; i++) shadow[i] = mem[i];
      @(negedge clk);
      chk("rst_req", mem_req, 0);       chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);     chk("rst_wdata", mem_wdata, 0);
      chk("rst_coef", coef_out, 0);     chk("rst_samp", samp_out, 0);
      chk("rst_pv", pair_valid, 0);     chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);         chk("rst_overrun", overrun, 0);
   endtask

   initial begin
      int found, fd, tc;
      rst = 1'b1; sample_tick = 1'b0; record_en = 1'b0; sample_in = 16'd0; tap_count = 16'd0;
      mem_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      repeat (3) @(posedge clk);
      do_reset(1'b0);

      log_addr.delete(); log_we.delete();
      frame(1, 3, 16'h1234);
      chk("lit_log_len", log_addr.size(), 7);
      if (log_addr.size() == 7)
         for (int i = 0; i < 7; i++) begin
            chk("lit_addr", log_addr[i], lit_addr[i]);
            chk("lit_we", log_we[i], (i == 0) ? 1 : 0);
         end
      chk("lit_wdata_mem", mem[4], 16'h1234);
      chk("lit_first_pair", first_pair_cyc - tick_cyc, 4);
      chk("lit_done_at", done_cyc - tick_cyc, 8);

      do_reset(1'b0);
      for (int f = 0; f < 6; f++) frame(1, 3, 16'($urandom));
      log_addr.delete(); log_we.delete();
      frame(1, 3, 16'($urandom));
      chk("wrap_write_addr", log_addr[0], 4);
      chk("wrap_write_we", log_we[0], 1);
      chk("wrap_k1_samp", log_addr[4], 9);

      frame(1, 100, 16'($urandom));
      chk("clamp_pairs", pairs_seen, 4);

      frame(0, 0, 16'($urandom));
      chk("norec_no_req", req_cycles, 0);
      chk("norec_done_at", done_cyc - tick_cyc, 1);
      chk("overrun_clean", overrun, 0);

      mode = 1;
      frame(1, 3, 16'($urandom));
      chk("stall_done_at", done_cyc - tick_cyc, 29);

      start_frame(1, 3, 16'($urandom));
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mem_req && !mem_we && mem_addr >= 16'd4) begin found = 1; break; end
      end
      chk("overrun_window", found, 1);
      @(posedge clk); #1; sample_tick = 1'b1; tap_count = 16'd1;
      @(posedge clk); #1; sample_tick = 1'b0;
      wait_frame();
      chk("overrun_set", overrun, 1);

      for (int f = 0; f < 40; f++) begin
         mode = $urandom_range(0, 2);
         tc = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 7);
         frame($urandom_range(0, 1), tc, 16'($urandom));
      end
      chk("overrun_sticky", overrun, 1);

      mode = 0;
      start_frame(1, 4, 16'($urandom));
      repeat (3) @(negedge clk);
      do_reset(1'b1);
      fd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_done || busy) fd++;
      end
      chk("abort_quiet", fd, 0);
      log_addr.delete(); log_we.delete();
      frame(1, 2, 16'($urandom));
      chk("abort_first_write", log_addr[0], 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
